conv_front_sequencer: RTL and testbench

//  Layer-level controller for the conv front datapath (router, shift regs, BRAM handler, ROM/slab stores).

---
 rtl/conv_front_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_conv_front_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_front_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_front_sequencer
// Brief    : Layer controller for the conv front datapath. Queues host layer
//            descriptors, derives ox/oy and log2 exponents, sequences
//            dp_reset / dp_en / drain / done. Optional CONV_SEQ_PERF_EN macro
//            adds run_cycles and layers_done counters.
// Revision : 1.0 - initial release
// ============================================================================
module conv_front_sequencer #(
    parameter int DESC_DEPTH      = 4,
    parameter int DESC_DEPTH_LOG2 = 2,
    parameter int DRAIN_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [15:0] desc_ix,
    input  logic [15:0] desc_iy,
    input  logic [15:0] desc_nif,
    input  logic [3:0]  desc_k,
    input  logic [3:0]  desc_s,
    input  logic [3:0]  desc_p,
    input  logic        abort,
    input  logic        conv_end,
    output logic        dp_reset,
    output logic        dp_en,
    output logic [15:0] ox,
    output logic [15:0] oy,
    output logic [15:0] ix,
    output logic [15:0] iy,
    output logic [15:0] nif,
    output logic [3:0]  k,
    output logic [3:0]  s,
    output logic [3:0]  p,
    output logic [15:0] nif_in_2pow,
    output logic [15:0] ix_in_2pow,
    output logic        busy,
    output logic        layer_done,
    output logic        layer_err
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0] run_cycles,
    output logic [15:0] layers_done
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_ARM   = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [DESC_DEPTH_LOG2:0] c_full       = (DESC_DEPTH_LOG2+1)'(DESC_DEPTH);
    localparam logic [7:0]               c_drain_last = 8'(DRAIN_CYCLES - 1);

    logic [2:0]                 r_state;
    logic [2:0]                 w_next;
    logic [59:0]                r_fifo [DESC_DEPTH];
    logic [DESC_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DESC_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DESC_DEPTH_LOG2:0]   r_count;
    logic [59:0]                r_cur;
    logic [7:0]                 r_drain_cnt;
    logic                       w_push;
    logic                       w_pop;

    // Smallest n with 2^n >= x; x == 0 is filtered out by validation.
    function automatic logic [4:0] f_clog2(input logic [15:0] x);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if ((17'd1 << i) < {1'b0, x}) n = 5'(i + 1);
        end
        return n;
    endfunction

    assign desc_ready = (r_count != c_full);
    assign w_push     = desc_valid & desc_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0) && !abort;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {desc_ix, desc_iy, desc_nif, desc_k, desc_s, desc_p};
    end

    // abort flushes the queue, including any push offered in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_cur    <= '0;
        end else if (abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_cur    <= r_fifo[r_rd_ptr];
            end
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    logic [15:0] w_ix, w_iy, w_nif;
    logic [3:0]  w_k, w_s, w_p;
    logic [16:0] w_pad2, w_k17, w_ix_sum, w_iy_sum, w_ix_diff, w_iy_diff, w_ox17, w_oy17;
    logic        w_valid;

    assign {w_ix, w_iy, w_nif, w_k, w_s, w_p} = r_cur;
    assign w_pad2    = {12'd0, w_p, 1'b0};
    assign w_k17     = {13'd0, w_k};
    assign w_ix_sum  = {1'b0, w_ix} + w_pad2;
    assign w_iy_sum  = {1'b0, w_iy} + w_pad2;
    assign w_ix_diff = w_ix_sum - w_k17;
    assign w_iy_diff = w_iy_sum - w_k17;
    assign w_ox17    = ((w_s == 4'd2) ? (w_ix_diff >> 1) : w_ix_diff) + 17'd1;
    assign w_oy17    = ((w_s == 4'd2) ? (w_iy_diff >> 1) : w_iy_diff) + 17'd1;
    assign w_valid   = (w_k != 4'd0) && ((w_s == 4'd1) || (w_s == 4'd2)) && (w_nif != 16'd0)
                    && (w_ix_sum >= w_k17) && (w_iy_sum >= w_k17);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_next = S_LOAD;
            S_LOAD:  w_next = S_CALC;
            S_CALC:  w_next = w_valid ? S_ARM : S_ERR;
            S_ARM:   w_next = S_RUN;
            S_RUN:   if (conv_end) w_next = S_DRAIN;
            S_DRAIN: if (r_drain_cnt == c_drain_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_drain_cnt <= '0;
        else if (r_state != S_DRAIN) r_drain_cnt <= '0;
        else                        r_drain_cnt <= r_drain_cnt + 8'd1;
    end

    // Config is committed on the CALC->ARM edge and held until the next layer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ox <= '0; oy <= '0; ix <= '0; iy <= '0; nif <= '0;
            k  <= '0; s  <= '0; p  <= '0;
            nif_in_2pow <= '0;
            ix_in_2pow  <= '0;
        end else if ((r_state == S_CALC) && w_valid && !abort) begin
            ox  <= w_ox17[15:0];
            oy  <= w_oy17[15:0];
            ix  <= w_ix;
            iy  <= w_iy;
            nif <= w_nif;
            k   <= w_k;
            s   <= w_s;
            p   <= w_p;
            nif_in_2pow <= {11'd0, f_clog2(w_nif)};
            ix_in_2pow  <= {11'd0, f_clog2(w_ix)};
        end
    end

    assign dp_reset   = (r_state == S_ARM);
    assign dp_en      = (r_state == S_RUN);
    assign busy       = (r_state != S_IDLE);
    assign layer_done = (r_state == S_DONE);
    assign layer_err  = (r_state == S_ERR);

`ifdef CONV_SEQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cycles  <= '0;
            layers_done <= '0;
        end else begin
            if (r_state == S_ARM)      run_cycles <= '0;
            else if (r_state == S_RUN) run_cycles <= run_cycles + 32'd1;
            if (r_state == S_DONE)     layers_done <= layers_done + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_front_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_front_sequencer
// Brief    : Directed self-checking bench for conv_front_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_front_sequencer;

    logic        clk;
    logic        reset;
    logic        desc_valid;
    logic        desc_ready;
    logic [15:0] desc_ix, desc_iy, desc_nif;
    logic [3:0]  desc_k, desc_s, desc_p;
    logic        abort, conv_end;
    logic        dp_reset, dp_en;
    logic [15:0] ox, oy, ix, iy, nif;
    logic [3:0]  k, s, p;
    logic [15:0] nif_in_2pow, ix_in_2pow;
    logic        busy, layer_done, layer_err;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0] run_cycles;
    logic [15:0] layers_done;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    conv_front_sequencer #(
        .DESC_DEPTH(4), .DESC_DEPTH_LOG2(2), .DRAIN_CYCLES(4)
    ) u_dut (
        .clk(clk), .reset(reset),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_ix(desc_ix), .desc_iy(desc_iy), .desc_nif(desc_nif),
        .desc_k(desc_k), .desc_s(desc_s), .desc_p(desc_p),
        .abort(abort), .conv_end(conv_end),
        .dp_reset(dp_reset), .dp_en(dp_en),
        .ox(ox), .oy(oy), .ix(ix), .iy(iy), .nif(nif),
        .k(k), .s(s), .p(p),
        .nif_in_2pow(nif_in_2pow), .ix_in_2pow(ix_in_2pow),
        .busy(busy), .layer_done(layer_done), .layer_err(layer_err)
`ifdef CONV_SEQ_PERF_EN
        , .run_cycles(run_cycles), .layers_done(layers_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] a_ix, input logic [15:0] a_iy, input logic [15:0] a_nif,
                        input logic [3:0] a_k, input logic [3:0] a_s, input logic [3:0] a_p);
        desc_valid = 1'b1;
        desc_ix = a_ix; desc_iy = a_iy; desc_nif = a_nif;
        desc_k = a_k; desc_s = a_s; desc_p = a_p;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic wait_arm(input string tag);
        int n = 0;
        while (!dp_reset && n < 30) begin tick(); n++; end
        check(tag, 32'(dp_reset), 1);
        check({tag, "_en_low"}, 32'(dp_en), 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!layer_done && n < 30) begin tick(); n++; end
        check(tag, 32'(layer_done), 1);
        if (layer_done) n_done++;
        tick();
        check({tag, "_pulse"}, 32'(layer_done), 0);
    endtask

    // From the ARM cycle: run `cycles` RUN cycles with conv_end on the last one.
    task automatic run_to_end(input int cycles);
        tick();
        check("run_en", 32'(dp_en), 1);
        repeat (cycles - 1) tick();
        conv_end = 1'b1;
        tick();
        conv_end = 1'b0;
        check("en_drop", 32'(dp_en), 0);
    endtask

    int exp_ix  [4] = '{1, 5, 9, 13};
    int exp_nif [4] = '{1, 2, 4, 17};
    int exp_ix2 [4] = '{0, 3, 4, 4};
    int exp_nf2 [4] = '{0, 1, 2, 5};

    initial begin
        int seen;
        int n;
        reset = 1'b1; desc_valid = 1'b0; abort = 1'b0; conv_end = 1'b0;
        desc_ix = '0; desc_iy = '0; desc_nif = '0; desc_k = '0; desc_s = '0; desc_p = '0;
        tick(); tick();
        check("rst_ready", 32'(desc_ready), 1);
        check("rst_busy",  32'(busy), 0);
        check("rst_en",    32'(dp_en), 0);
        check("rst_dprst", 32'(dp_reset), 0);
        check("rst_ox",    32'(ox), 0);
        check("rst_nif2",  32'(nif_in_2pow), 0);
        reset = 1'b0;
        tick();

`ifdef CONV_SEQ_PERF_EN
        push(16, 16, 32, 3, 1, 1);
        wait_arm("perf_arm");
        run_to_end(51);
        wait_done("perf_done");
        check("perf_run_cycles", run_cycles, 51);
        check("perf_layers", 32'(layers_done), 1);
`endif

        // Layer 1: 16x16x32, k3 s1 p1
        push(16, 16, 32, 3, 1, 1);
        wait_arm("l1_arm");
        check("l1_ox", 32'(ox), 16);
        check("l1_oy", 32'(oy), 16);
        check("l1_ix2", 32'(ix_in_2pow), 4);
        check("l1_nif2", 32'(nif_in_2pow), 5);
        tick();
        check("l1_dprst_1cyc", 32'(dp_reset), 0);
        check("l1_en", 32'(dp_en), 1);
        repeat (3) tick();
        conv_end = 1'b1; tick(); conv_end = 1'b0;
        check("l1_en_drop", 32'(dp_en), 0);
        wait_done("l1_done");

        // Layer 2: stride 2, conv_end on RUN cycle 100
        push(32, 8, 3, 3, 2, 1);
        wait_arm("l2_arm");
        check("l2_ox", 32'(ox), 16);
        check("l2_oy", 32'(oy), 4);
        check("l2_nif2", 32'(nif_in_2pow), 2);
        check("l2_ix2", 32'(ix_in_2pow), 5);
        check("l2_s", 32'(s), 2);
        run_to_end(100);
        check("l2_busy_drain", 32'(busy), 1);
        seen = 0;
        repeat (3) begin tick(); seen += int'(layer_done); end
        check("l2_no_early_done", seen, 0);
        tick();
        check("l2_done_at_4", 32'(layer_done), 1);
        tick();
        check("l2_idle", 32'(busy), 0);
        check("l2_ox_hold", 32'(ox), 16);

        // Rejected descriptor (stride 3)
        push(16, 16, 32, 3, 3, 1);
        seen = 0; n = 0;
        while (!layer_err && n < 20) begin seen += int'(dp_en | dp_reset); tick(); n++; end
        check("err_pulse", 32'(layer_err), 1);
        tick();
        check("err_1cyc", 32'(layer_err), 0);
        check("err_busy", 32'(busy), 0);
        check("err_no_dp", seen, 0);
        check("err_ox_hold", 32'(ox), 16);

        // Queue fill while a layer runs, then run queued layers in order
        push(16, 16, 32, 3, 1, 1);
        wait_arm("q0_arm");
        tick();
        for (int i = 0; i < 4; i++) begin
            push(16'(exp_ix[i]), 4, 16'(exp_nif[i]), 3, 1, 1);
            check($sformatf("q_ready_%0d", i), 32'(desc_ready), (i == 3) ? 0 : 1);
        end
        push(100, 100, 8, 3, 1, 1);
        check("q_ready_full", 32'(desc_ready), 0);
        conv_end = 1'b1; tick(); conv_end = 1'b0;
        wait_done("q0_done");
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            wait_arm($sformatf("q%0d_arm", i + 1));
            check($sformatf("q%0d_ix", i + 1), 32'(ix), exp_ix[i]);
            check($sformatf("q%0d_ox", i + 1), 32'(ox), exp_ix[i]);
            check($sformatf("q%0d_ix2", i + 1), 32'(ix_in_2pow), exp_ix2[i]);
            check($sformatf("q%0d_nif2", i + 1), 32'(nif_in_2pow), exp_nf2[i]);
            run_to_end(3);
            wait_done($sformatf("q%0d_done", i + 1));
        end
        check("q_done_count", n_done, 4);
        seen = 0;
        repeat (15) begin tick(); seen += int'(dp_reset | busy); end
        check("q_fifth_dropped", seen, 0);

        // Abort on RUN cycle 10 with two queued
        push(16, 16, 32, 3, 1, 1);
        wait_arm("ab_arm");
        tick();
        push(16, 16, 32, 3, 1, 1);
        push(16, 16, 32, 3, 1, 1);
        repeat (7) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("ab_en", 32'(dp_en), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_ready", 32'(desc_ready), 1);
        seen = 0;
        repeat (15) begin tick(); seen += int'(layer_done | dp_reset | busy); end
        check("ab_flushed", seen, 0);

        // abort and conv_end together
        push(16, 16, 32, 3, 1, 1);
        wait_arm("abce_arm");
        repeat (5) tick();
        abort = 1'b1; conv_end = 1'b1; tick(); abort = 1'b0; conv_end = 1'b0;
        check("abce_en", 32'(dp_en), 0);
        check("abce_busy", 32'(busy), 0);
        seen = 0;
        repeat (10) begin tick(); seen += int'(layer_done | busy); end
        check("abce_no_done", seen, 0);

        // Boundary: ix+2p == k gives ox 1
        push(1, 1, 1, 3, 1, 1);
        wait_arm("bnd_arm");
        check("bnd_ox", 32'(ox), 1);
        check("bnd_nif2", 32'(nif_in_2pow), 0);

        // Asynchronous reset mid-RUN
        tick();
        check("ar_en_before", 32'(dp_en), 1);
        #2 reset = 1'b1;
        #1;
        check("ar_en", 32'(dp_en), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_ox", 32'(ox), 0);
        tick();
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
